// File: rtl/bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned WIDTH_DEFAULT      = 32;
  localparam int unsigned BCD_DIGITS_DEFAULT = 10;
  localparam int unsigned OUT_DIGITS_DEFAULT = 3;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_t;

  // Iteration counter width; must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the datapath and the BCD converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned OUT_DIGITS = OUT_DIGITS_DEFAULT
);

  logic                    start;
  logic [WIDTH-1:0]        num;
  logic                    busy;
  logic                    done;
  logic [4*OUT_DIGITS-1:0] bcd;
  logic                    overflow;

  modport master (
    output start,
    output num,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  num,
    output busy,
    output done,
    output bcd,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter; one bit per clock, low digits driven out.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned BCD_DIGITS = BCD_DIGITS_DEFAULT,
  parameter int unsigned OUT_DIGITS = OUT_DIGITS_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned AccW = 4 * BCD_DIGITS;
  localparam int unsigned OutW = 4 * OUT_DIGITS;

  state_t          state_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] acc_adj;
  logic [AccW-1:0] acc_next;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_next;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [OutW-1:0] bcd_q;
  logic            ovf_q;
  logic            ovf_next;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc_q[4*i +: 4]),
      .adjusted (acc_adj[4*i +: 4])
    );
  end

  always_comb begin
    acc_next   = {acc_adj[AccW-2:0], shreg_q[WIDTH-1]};
    shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
  end

  // A carry out of the top digit can only mean the value does not fit the outputs either.
  if (BCD_DIGITS > OUT_DIGITS) begin : g_ovf
    assign ovf_next = |{acc_adj[AccW-1], acc_next[AccW-1:OutW]};
  end else begin : g_no_ovf
    assign ovf_next = acc_adj[AccW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            shreg_q <= bus.num;
            acc_q   <= '0;
            cnt_q   <= CntW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q   <= acc_next;
          shreg_q <= shreg_next;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            bcd_q   <= acc_next[OutW-1:0];
            ovf_q   <= ovf_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble, shift-and-add-3) that sits directly upstream of the seven-segment digit decoder.
- Accepts a 32-bit unsigned result from the processor datapath on a start pulse.
- Produces three registered BCD digits (units, tens, hundreds) plus an overflow flag, replacing divide/modulo logic with one shift per clock.

Parameters:
- WIDTH, 32, bit width of binary input.
- BCD_DIGITS, 10, internal BCD digit count; must hold 2^WIDTH-1 (10 for WIDTH=32).
- OUT_DIGITS, 3, number of least-significant BCD digits driven out.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; honoured only when busy=0.
- num  input  WIDTH  unsigned binary value; sampled on the accepted start edge only.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bcd/overflow updated this cycle.
- bcd  output  4*OUT_DIGITS  [3:0]=units, [7:4]=tens, [11:8]=hundreds.
- overflow  output  1  1 when num > 10^OUT_DIGITS-1 (any internal digit above OUT_DIGITS nonzero).

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-conversion):
  - state=IDLE, busy=0, done=0, bcd=0 (reads "000"), overflow=0.
  - Shift/BCD working registers and the iteration counter are cleared.
  - The aborted conversion produces no done pulse.
- States: IDLE, SHIFT.
- IDLE: if start=1 at an edge:
  - capture num into the shift register, clear the BCD accumulator, counter=WIDTH-1, go to SHIFT.
  - busy=1 from the next cycle.
  - Otherwise hold.
- SHIFT, one iteration per clock:
  - every accumulator digit >=5 gets +3.
  - then {accumulator, shift register} shifts left by 1.
  - counter decrements.
  - when an iteration runs with counter=0: load bcd from the low OUT_DIGITS of the post-shift accumulator, load overflow from the OR of the higher digits, assert done for the next cycle, return to IDLE.
- Latency: start accepted at edge E0 -> busy=1 in cycles after E0 through E32 -> done=1, busy=0, new bcd valid in the cycle after E32 (exactly WIDTH+1 cycles after start sampled).
- done is a single-cycle pulse. bcd and overflow hold their values until the next completion or reset.
- Start while busy=1 is ignored: not queued, num not resampled.
- Start in the done cycle is accepted, because busy=0 then; back-to-back conversions run every WIDTH+1 cycles.
- Changes on num outside the accepted start edge have no effect.
- bcd always holds num mod 1000 as valid BCD (each nibble 0-9), including when overflow=1.
- Arithmetic: digit correction is 4-bit unsigned; no carry between digits beyond the shift.

Decomposition:
- Shared package bcd_pkg, containing:
  - state enum (IDLE, SHIFT).
  - constants WIDTH_DEFAULT=32, BCD_DIGITS_DEFAULT=10, OUT_DIGITS_DEFAULT=3.
  - function/constant for counter width (clog2 WIDTH).
- One sub-module: bcd_digit_adj (4-bit in, 4-bit out, adds 3 when input >=5). Instantiated BCD_DIGITS times via generate.

Test Plan:
- Reset, then start with num=0 -> done exactly 33 cycles after start edge; bcd=12'h000, overflow=0.
- num=255 -> bcd=12'h255, overflow=0; busy high for exactly 32 cycles, done high exactly 1 cycle.
- num=999 -> bcd=12'h999, overflow=0.
- num=1000 -> bcd=12'h000, overflow=1.
- num=32'hFFFFFFFF -> bcd=12'h295, overflow=1.
- Back-to-back requests with num=123:
  - start pulsed again 5 cycles after acceptance with num=456 -> ignored, result 12'h123.
  - start in the done cycle with num=77 -> accepted; the following done gives bcd=12'h077.
- Reset mid-conversion:
  - rst asserted 10 cycles into a conversion of 789 -> busy=0, bcd=0, and no done pulse.
  - a new start with 42 afterwards -> bcd=12'h042 after 33 cycles.
